// File: rtl/unit_hazard_control_pkg.sv
// Shared hazard-control definitions: FSM encodings and drain depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package unit_hazard_control_pkg;

    // Encodings are read by the debug unit alongside o_halted, so keep them fixed.
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } hz_state_e;

    // One step per stage behind ID that must retire before the core is quiet: EX, MEM, WB.
    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/unit_hazard_detect.sv
// Load-use comparator: flags an ID instruction that needs a register a load in EX has not yet produced.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on o_load_use.
module unit_hazard_detect #(
    parameter int BITS_REGS = 5
) (
    input  logic                 i_IDEX_mem_read,
    input  logic [BITS_REGS-1:0] i_IDEX_rt,
    input  logic [BITS_REGS-1:0] i_IFID_rs,
    input  logic [BITS_REGS-1:0] i_IFID_rt,
    input  logic                 i_IFID_uses_rt,
    output logic                 o_load_use
);

    logic rs_hit;
    logic rt_hit;

    // $zero is never a real dependency, so a load targeting r0 cannot cause a stall.
    assign rs_hit     = (i_IDEX_rt == i_IFID_rs);
    assign rt_hit     = i_IFID_uses_rt && (i_IDEX_rt == i_IFID_rt);
    assign o_load_use = i_IDEX_mem_read && (i_IDEX_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/unit_hazard_control.sv
// ID-stage hazard control: load-use stalls, branch flushes and HALT drain for the 5-stage core.
// Latency: control outputs are combinational (act at the next edge); halted/stall count are registered.
// Backpressure: i_step=0 freezes every latch and all internal state for that cycle.
module unit_hazard_control
    import unit_hazard_control_pkg::*;
#(
    parameter int BITS_REGS      = 5,
    parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
    parameter int BITS_DRAIN     = 2,
    parameter int BITS_STALL_CNT = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_step,
    input  logic                      i_IDEX_mem_read,
    input  logic [BITS_REGS-1:0]      i_IDEX_rt,
    input  logic [BITS_REGS-1:0]      i_IFID_rs,
    input  logic [BITS_REGS-1:0]      i_IFID_rt,
    input  logic                      i_IFID_uses_rt,
    input  logic                      i_branch_taken,
    input  logic                      i_halt_id,
    output logic                      o_pc_write,
    output logic                      o_IFID_write,
    output logic                      o_IFID_flush,
    output logic                      o_IDEX_bubble,
    output logic                      o_halted,
    output logic [BITS_STALL_CNT-1:0] o_stall_count
);

    localparam logic [BITS_DRAIN-1:0]     DRAIN_LOAD = BITS_DRAIN'(DRAIN_CYCLES);
    localparam logic [BITS_DRAIN-1:0]     DRAIN_LAST = BITS_DRAIN'(1);
    localparam logic [BITS_STALL_CNT-1:0] STALL_ONE  = BITS_STALL_CNT'(1);

    hz_state_e                 state_q, state_d;
    logic [BITS_DRAIN-1:0]     drain_q, drain_d;
    logic [BITS_STALL_CNT-1:0] stall_q, stall_d;
    logic                      load_use;

    unit_hazard_detect #(
        .BITS_REGS (BITS_REGS)
    ) u_detect (
        .i_IDEX_mem_read (i_IDEX_mem_read),
        .i_IDEX_rt       (i_IDEX_rt),
        .i_IFID_rs       (i_IFID_rs),
        .i_IFID_rt       (i_IFID_rt),
        .i_IFID_uses_rt  (i_IFID_uses_rt),
        .o_load_use      (load_use)
    );

    // State, drain countdown and stall statistics; all clear immediately on reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    // Next-state and latch-control mux; HALT outranks load-use, which outranks a taken branch.
    always_comb begin
        o_pc_write    = 1'b0;
        o_IFID_write  = 1'b0;
        o_IFID_flush  = 1'b0;
        o_IDEX_bubble = 1'b0;
        state_d       = state_q;
        drain_d       = drain_q;
        stall_d       = stall_q;
        if (!i_reset) begin
            // Keep garbage out of ID/EX while reset is held.
            o_IDEX_bubble = 1'b1;
        end else if (i_step) begin
            case (state_q)
                RUN: begin
                    if (i_halt_id) begin
                        // HALT is held in ID and never issued; older instructions drain behind it.
                        o_IDEX_bubble = 1'b1;
                        state_d       = DRAIN;
                        drain_d       = DRAIN_LOAD;
                    end else if (load_use) begin
                        // A coincident taken branch is dropped here and re-resolves next cycle.
                        o_IDEX_bubble = 1'b1;
                        if (stall_q != '1) begin
                            stall_d = stall_q + STALL_ONE;
                        end
                    end else begin
                        o_pc_write   = 1'b1;
                        o_IFID_write = 1'b1;
                        o_IFID_flush = i_branch_taken;
                    end
                end
                DRAIN: begin
                    o_IDEX_bubble = 1'b1;
                    drain_d       = drain_q - DRAIN_LAST;
                    if (drain_q == DRAIN_LAST) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    o_IDEX_bubble = 1'b1;
                end
                default: begin
                    o_IDEX_bubble = 1'b1;
                    state_d       = RUN;
                end
            endcase
        end
    end

    assign o_halted      = (state_q == HALTED);
    assign o_stall_count = stall_q;

endmodule
